clock_time_set_ctrl: RTL

//  Time-set sequencer for the 12-hour BCD clock (hh 01..12, mm 00..59).

---
 rtl/clock_time_set_ctrl_if.sv | 43 ++++
 rtl/clock_time_set_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_set_ctrl_if.sv
// Interface: clock_time_set_ctrl_if
// Carries the time-set controller's exchange with the timekeeper and the display drivers.
//   hh_in, mm_in        current time from the timekeeper, packed BCD
//   run_en, load        timekeeper freeze / one-cycle load strobe
//   hh_out, mm_out      edited time, packed BCD
//   blank_hh, blank_mm  per-field blink masks for the seven-segment controllers
//   state               session state for debug / LEDs
// master: the time-set controller. slave: timekeeper + display side.
interface clock_time_set_ctrl_if;
    logic [7:0] hh_in;
    logic [7:0] mm_in;
    logic       run_en;
    logic       load;
    logic [7:0] hh_out;
    logic [7:0] mm_out;
    logic       blank_hh;
    logic       blank_mm;
    logic [1:0] state;

    modport master (
        input  hh_in,
        input  mm_in,
        output run_en,
        output load,
        output hh_out,
        output mm_out,
        output blank_hh,
        output blank_mm,
        output state
    );

    modport slave (
        output hh_in,
        output mm_in,
        input  run_en,
        input  load,
        input  hh_out,
        input  mm_out,
        input  blank_hh,
        input  blank_mm,
        input  state
    );
endinterface

// File: rtl/clock_time_set_ctrl.sv
// Module: clock_time_set_ctrl
// Time-set sequencer for a 12-hour BCD clock. Two raw buttons (MODE, INC) open an edit
// session that freezes the timekeeper, edits hours then minutes, and commits them with a
// one-cycle load strobe. Sessions abort after TIMEOUT_TICKS idle seconds.
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   tick_1hz  one-clk pulse per second
//   btn_mode  raw MODE button (async, active-high)
//   btn_inc   raw INC button (async, active-high)
//   bus       master side of clock_time_set_ctrl_if (time in/out, run_en, load, blanks, state)
module clock_time_set_ctrl #(
    parameter logic [19:0] DEBOUNCE_CYC  = 20'd999_999,
    parameter logic [26:0] REPEAT_CYC    = 27'd24_999_999,
    parameter logic [5:0]  TIMEOUT_TICKS = 6'd30
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick_1hz,
    input  logic                        btn_mode,
    input  logic                        btn_inc,
    clock_time_set_ctrl_if.master       bus
);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StSetHh  = 2'b01,
        StSetMm  = 2'b10,
        StCommit = 2'b11
    } state_e;

    // Button index 0 = MODE, 1 = INC.
    logic [1:0]  sync1_q;
    logic [1:0]  sync2_q;
    logic [1:0]  deb_q;
    logic [1:0]  deb_prev_q;
    logic [19:0] deb_cnt_q [2];
    logic [26:0] rep_cnt_q;

    logic        mode_press;
    logic        inc_press;
    logic        inc_rep;
    logic        inc_pulse;

    state_e      state_q;
    logic        run_en_q;
    logic        load_q;
    logic [7:0]  hh_q;
    logic [7:0]  mm_q;
    logic        phase_q;
    logic [5:0]  to_cnt_q;

    // Hours 01..12; anything else steps to 01.
    function automatic logic [7:0] next_hh(input logic [7:0] h);
        logic legal;
        legal = ((h[7:4] == 4'd0) && (h[3:0] >= 4'd1) && (h[3:0] <= 4'd9)) ||
                ((h[7:4] == 4'd1) && (h[3:0] <= 4'd2));
        if (!legal || (h == 8'h12)) begin
            next_hh = 8'h01;
        end else if (h[3:0] == 4'd9) begin
            next_hh = 8'h10;
        end else begin
            next_hh = {h[7:4], h[3:0] + 4'd1};
        end
    endfunction

    // Minutes 00..59, wrapping without carrying into hours; illegal values step to 00.
    function automatic logic [7:0] next_mm(input logic [7:0] m);
        logic legal;
        legal = (m[7:4] <= 4'd5) && (m[3:0] <= 4'd9);
        if (!legal || (m == 8'h59)) begin
            next_mm = 8'h00;
        end else if (m[3:0] == 4'd9) begin
            next_mm = {m[7:4] + 4'd1, 4'd0};
        end else begin
            next_mm = {m[7:4], m[3:0] + 4'd1};
        end
    endfunction

    // Synchronise and debounce both buttons. The counter only runs while the synced level
    // differs from the accepted one, so any bounce back restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_prev_q   <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
        end else begin
            sync1_q    <= {btn_inc, btn_mode};
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEBOUNCE_CYC - 20'd1) begin
                    deb_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 20'd1;
                end
            end
        end
    end

    assign mode_press = deb_q[0] & ~deb_prev_q[0];
    assign inc_press  = deb_q[1] & ~deb_prev_q[1];

    // rep_cnt_q is 0 in the press cycle, so it reaches REPEAT_CYC exactly REPEAT_CYC clk later;
    // reloading with 1 keeps the same spacing for every subsequent repeat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt_q <= '0;
        end else if (!deb_q[1]) begin
            rep_cnt_q <= '0;
        end else if (rep_cnt_q == REPEAT_CYC) begin
            rep_cnt_q <= 27'd1;
        end else begin
            rep_cnt_q <= rep_cnt_q + 27'd1;
        end
    end

    assign inc_rep   = deb_q[1] & deb_prev_q[1] & (rep_cnt_q == REPEAT_CYC);
    assign inc_pulse = inc_press | inc_rep;

    // Session FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StRun;
            run_en_q <= 1'b1;
            load_q   <= 1'b0;
            hh_q     <= 8'h12;
            mm_q     <= 8'h00;
            phase_q  <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    run_en_q <= 1'b1;
                    load_q   <= 1'b0;
                    phase_q  <= 1'b0;
                    to_cnt_q <= '0;
                    if (mode_press) begin
                        state_q  <= StSetHh;
                        hh_q     <= bus.hh_in;
                        mm_q     <= bus.mm_in;
                        run_en_q <= 1'b0;
                    end
                end
                StSetHh, StSetMm: begin
                    if (to_cnt_q == TIMEOUT_TICKS) begin
                        // Abort: edits are discarded because load never fires.
                        state_q  <= StRun;
                        run_en_q <= 1'b1;
                        phase_q  <= 1'b0;
                        to_cnt_q <= '0;
                    end else if (mode_press) begin
                        // MODE takes priority over a coincident INC.
                        to_cnt_q <= '0;
                        if (state_q == StSetHh) begin
                            state_q <= StSetMm;
                        end else begin
                            state_q <= StCommit;
                            load_q  <= 1'b1;
                        end
                    end else if (inc_pulse) begin
                        to_cnt_q <= '0;
                        phase_q  <= 1'b0;
                        if (state_q == StSetHh) begin
                            hh_q <= next_hh(hh_q);
                        end else begin
                            mm_q <= next_mm(mm_q);
                        end
                    end else if (tick_1hz) begin
                        to_cnt_q <= to_cnt_q + 6'd1;
                        phase_q  <= ~phase_q;
                    end
                end
                StCommit: begin
                    state_q  <= StRun;
                    load_q   <= 1'b0;
                    run_en_q <= 1'b1;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    assign bus.run_en   = run_en_q;
    assign bus.load     = load_q;
    assign bus.hh_out   = hh_q;
    assign bus.mm_out   = mm_q;
    assign bus.blank_hh = (state_q == StSetHh) & phase_q;
    assign bus.blank_mm = (state_q == StSetMm) & phase_q;
    assign bus.state    = state_q;

endmodule
